mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter_rr_picker.sv | 22 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: command layout, FSM encoding and
// port ownership, plus a small helper used by the round-robin picker.
package mem_arbiter_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;

   // Memory command at the default bus widths.
   typedef struct packed {
      logic                      we;
      logic [ARB_ADDR_W-1:0]     addr;
      logic [ARB_DATA_W-1:0]     wdata;
      logic [ARB_DATA_W/8-1:0]   be;
   } mem_cmd_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_AUX  = 1'b1
   } owner_t;

   // The port that did not win last time.
   function automatic owner_t other_port(input owner_t o);
      return (o == OWN_CORE) ? OWN_AUX : OWN_CORE;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the core request port, aux request port and memory command port.
// slave is the arbiter's view; master is the view of the requesters and the
// memory model around it.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  core_req;
   logic                  core_we;
   logic [ADDR_W-1:0]     core_addr;
   logic [DATA_W-1:0]     core_wdata;
   logic [DATA_W/8-1:0]   core_be;
   logic                  core_stall;
   logic                  core_valid;
   logic [DATA_W-1:0]     core_rdata;

   logic                  aux_req;
   logic                  aux_we;
   logic [ADDR_W-1:0]     aux_addr;
   logic [DATA_W-1:0]     aux_wdata;
   logic [DATA_W/8-1:0]   aux_be;
   logic                  aux_valid;
   logic [DATA_W-1:0]     aux_rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata, core_be,
      input  aux_req, aux_we, aux_addr, aux_wdata, aux_be,
      input  mem_rdata,
      output core_stall, core_valid, core_rdata,
      output aux_valid, aux_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata, core_be,
      output aux_req, aux_we, aux_addr, aux_wdata, aux_be,
      output mem_rdata,
      input  core_stall, core_valid, core_rdata,
      input  aux_valid, aux_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// mem_rr_picker: combinational two-way round-robin choice. A lone requester
// always wins; on a tie the port not served last wins. Kept separate so a
// wider picker can drop in when more ports are added.
module mem_rr_picker
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,     // bit 0 = core, bit 1 = aux
   input  owner_t     last,
   output owner_t     owner
);

   // Pick the winner; with no request the result is unused by the arbiter.
   always_comb begin
      owner = OWN_CORE;
      if (req == 2'b10) begin
         owner = OWN_AUX;
      end else if (req == 2'b11) begin
         owner = other_port(last);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single-port, fixed-latency data memory between
// the core load/store path and the aux loader port. One access is in flight
// at a time; each grant ends with a single-cycle response on the owning port.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic         Clock,
   input  logic         Reset,
   mem_arbiter_if.slave bus
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(LATENCY + 1);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_ACCESS = ACCESS;
   localparam logic [1:0] S_DONE   = DONE;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } cmd_t;

   logic [1:0]        state_q;
   owner_t            owner_q;
   owner_t            last_q;
   owner_t            pick;
   logic [CNT_W-1:0]  cnt_q;
   cmd_t              cmd_q;
   cmd_t              sel_cmd;
   logic              mem_en_q;
   logic              core_valid_q;
   logic              aux_valid_q;
   logic [DATA_W-1:0] core_rdata_q;
   logic [DATA_W-1:0] aux_rdata_q;
   logic              any_req;
   logic              rsp_hit;

   assign any_req = bus.core_req | bus.aux_req;

   // Last wait cycle: mem_rdata is valid right now and the FSM leaves ACCESS.
   assign rsp_hit = (state_q == S_ACCESS) && !mem_en_q && (cnt_q == CNT_W'(1));

   mem_rr_picker u_picker (
      .req   ({bus.aux_req, bus.core_req}),
      .last  (last_q),
      .owner (pick)
   );

   // Route the winning port's command fields toward the command register.
   always_comb begin
      sel_cmd.we    = bus.core_we;
      sel_cmd.addr  = bus.core_addr;
      sel_cmd.wdata = bus.core_wdata;
      sel_cmd.be    = bus.core_be;
      if (pick == OWN_AUX) begin
         sel_cmd.we    = bus.aux_we;
         sel_cmd.addr  = bus.aux_addr;
         sel_cmd.wdata = bus.aux_wdata;
         sel_cmd.be    = bus.aux_be;
      end
   end

   // FSM, owner and last-served tracking, wait counter and memory command.
   // The strobe cycle loads the counter with LATENCY, so it reads 1 exactly
   // on the cycle the memory presents read data.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_CORE;
         last_q   <= OWN_AUX;
         cnt_q    <= '0;
         cmd_q    <= '0;
         mem_en_q <= 1'b0;
      end else begin
         mem_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  owner_q  <= pick;
                  cmd_q    <= sel_cmd;
                  mem_en_q <= 1'b1;
                  state_q  <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (mem_en_q) begin
                  cnt_q <= CNT_W'(LATENCY);
               end else if (rsp_hit) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               last_q  <= owner_q;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Response registers: loaded on the last wait cycle so they show in DONE,
   // zero in every other cycle; stores answer with zero data.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         core_valid_q <= 1'b0;
         aux_valid_q  <= 1'b0;
         core_rdata_q <= '0;
         aux_rdata_q  <= '0;
      end else begin
         core_valid_q <= rsp_hit && (owner_q == OWN_CORE);
         aux_valid_q  <= rsp_hit && (owner_q == OWN_AUX);
         core_rdata_q <= '0;
         aux_rdata_q  <= '0;
         if (rsp_hit && !cmd_q.we) begin
            if (owner_q == OWN_CORE) begin
               core_rdata_q <= bus.mem_rdata;
            end else begin
               aux_rdata_q  <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = cmd_q.we;
   assign bus.mem_addr   = cmd_q.addr;
   assign bus.mem_wdata  = cmd_q.wdata;
   assign bus.mem_be     = cmd_q.be;

   assign bus.core_valid = core_valid_q;
   assign bus.core_rdata = core_rdata_q;
   assign bus.aux_valid  = aux_valid_q;
   assign bus.aux_rdata  = aux_rdata_q;

   // The core pipeline advances on the edge that ends its response cycle.
   assign bus.core_stall = bus.core_req & ~core_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests push expected memory commands and
// responses into queues; a monitor pops and compares them as the DUT emits
// mem_en strobes and valid pulses. A memory model answers reads LATENCY
// cycles after each strobe.
module tb_mem_arbiter;

   localparam int LAT = 2;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] ret;
   } cmd_exp_t;

   typedef struct {
      bit          aux;
      logic [31:0] rdata;
   } rsp_exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;
   int   ret_cyc;
   int   en_cyc;
   logic [31:0] ret_val;

   cmd_exp_t exp_cmd[$];
   rsp_exp_t exp_rsp[$];
   int       en_log[$];

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .LATENCY (LAT)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input bit aux, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] ret, input logic [31:0] rdata);
      cmd_exp_t c;
      rsp_exp_t r;
      c.we = we; c.addr = addr; c.wdata = wdata; c.be = be; c.ret = ret;
      r.aux = aux; r.rdata = rdata;
      exp_cmd.push_back(c);
      exp_rsp.push_back(r);
   endtask

   task automatic drive(input bit aux, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (aux) begin
         bus.aux_req = 1'b1; bus.aux_we = we; bus.aux_addr = addr;
         bus.aux_wdata = wdata; bus.aux_be = be;
      end else begin
         bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr;
         bus.core_wdata = wdata; bus.core_be = be;
      end
   endtask

   // Wait for n valid pulses; drop each port after its own pulse, or both
   // ports after the last pulse when drop_each is 0.
   task automatic wait_grants(input int n, input bit drop_each);
      int seen;
      bit dc;
      bit da;
      seen = 0;
      for (int i = 0; i < 100 && seen < n; i++) begin
         dc = 0; da = 0;
         @(negedge clk);
         if (bus.core_valid) begin seen++; dc = 1; end
         if (bus.aux_valid)  begin seen++; da = 1; end
         @(posedge clk); #1;
         if (seen >= n) begin
            bus.core_req = 1'b0;
            bus.aux_req  = 1'b0;
         end else if (drop_each) begin
            if (dc) bus.core_req = 1'b0;
            if (da) bus.aux_req  = 1'b0;
         end
      end
      check("grant_count", 64'(seen), 64'(n));
   endtask

   // Memory model: read data only on the cycle it is due, garbage otherwise.
   initial begin
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_rdata = (cyc == ret_cyc) ? ret_val : 32'hBAD0_BAD0;
      end
   end

   // Monitor: compare every strobe and every response against the queues.
   initial begin
      cmd_exp_t c;
      rsp_exp_t r;
      forever begin
         @(negedge clk);
         if (bus.mem_en) begin
            en_log.push_back(cyc);
            en_cyc = cyc;
            if (exp_cmd.size() == 0) begin
               check("unexpected_mem_en", 64'(bus.mem_en), 64'(0));
            end else begin
               c = exp_cmd.pop_front();
               check("cmd_addr", 64'(bus.mem_addr), 64'(c.addr));
               check("cmd_we_be", 64'({bus.mem_we, bus.mem_be}), 64'({c.we, c.be}));
               check("cmd_wdata", 64'(bus.mem_wdata), 64'(c.wdata));
               ret_val = c.ret;
               ret_cyc = cyc + LAT;
            end
         end
         if (bus.core_valid || bus.aux_valid) begin
            if (exp_rsp.size() == 0) begin
               check("unexpected_valid", 64'({bus.core_valid, bus.aux_valid}), 64'(0));
            end else begin
               r = exp_rsp.pop_front();
               check("rsp_port", 64'({bus.core_valid, bus.aux_valid}),
                     r.aux ? 64'(2'b01) : 64'(2'b10));
               check("rsp_rdata", r.aux ? 64'(bus.aux_rdata) : 64'(bus.core_rdata), 64'(r.rdata));
               check("rsp_other_rdata", r.aux ? 64'(bus.core_rdata) : 64'(bus.aux_rdata), 64'(0));
               check("rsp_latency", 64'(cyc - en_cyc), 64'(LAT + 1));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      int t0;
      int busy;
      int vcount;
      int vcyc;
      cyc = 0; n_tests = 0; n_fail = 0; ret_cyc = -1; en_cyc = 0; ret_val = '0;
      rst = 1'b1;
      bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0; bus.core_be = '0;
      bus.aux_req = 1'b0;  bus.aux_we = 1'b0;  bus.aux_addr = '0;  bus.aux_wdata = '0;  bus.aux_be = '0;

      // Reset state, with core_req high to show core_stall following it.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_core_stall", 64'(bus.core_stall), 64'(1));
      check("rst_mem_en", 64'(bus.mem_en), 64'(0));
      check("rst_mem_cmd", 64'({bus.mem_we, bus.mem_addr, bus.mem_be}), 64'(0));
      check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
      check("rst_valids", 64'({bus.core_valid, bus.aux_valid}), 64'(0));
      check("rst_rdata", 64'({bus.core_rdata, bus.aux_rdata}), 64'(0));
      @(posedge clk); #1;
      bus.core_req = 1'b0;
      rst = 1'b0;

      // No requests: nothing moves.
      busy = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.mem_en || bus.core_valid || bus.aux_valid || bus.core_stall) busy++;
      end
      check("idle_no_activity", 64'(busy), 64'(0));

      // Core load at 0x100: strobe T1, data T3, valid T4, stall T0..T3.
      @(posedge clk); #1;
      t0 = cyc;
      push_exp(0, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      drive(0, 1'b0, 32'h100, 32'h0, 4'hF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("A_stall_T%0d", k), 64'(bus.core_stall), 64'(k < 4));
         check($sformatf("A_mem_en_T%0d", k), 64'(bus.mem_en), 64'(k == 1));
         check($sformatf("A_core_valid_T%0d", k), 64'(bus.core_valid), 64'(k == 4));
      end
      @(posedge clk); #1;
      bus.core_req = 1'b0;

      // From reset, both held: grants alternate core, aux, core, aux.
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      en_log.delete();
      t0 = cyc;
      push_exp(0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h1111_1111, 32'h1111_1111);
      push_exp(1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h2222_2222, 32'h2222_2222);
      push_exp(0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h1111_1111, 32'h1111_1111);
      push_exp(1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h2222_2222, 32'h2222_2222);
      drive(0, 1'b0, 32'h200, 32'h0, 4'hF);
      drive(1, 1'b0, 32'h300, 32'h0, 4'hF);
      wait_grants(4, 1'b0);
      check("B_strobe_count", 64'(en_log.size()), 64'(4));
      if (en_log.size() == 4) begin
         check("B_core_en_T1", 64'(en_log[0] - t0), 64'(1));
         check("B_aux_en_T6", 64'(en_log[1] - t0), 64'(6));
         check("B_core_en_T11", 64'(en_log[2] - t0), 64'(11));
         check("B_aux_en_T16", 64'(en_log[3] - t0), 64'(16));
      end

      // Another simultaneous pair after an aux grant: core first again.
      @(posedge clk); #1;
      push_exp(0, 1'b0, 32'h204, 32'h0, 4'hF, 32'h3333_3333, 32'h3333_3333);
      push_exp(1, 1'b0, 32'h304, 32'h0, 4'hF, 32'h4444_4444, 32'h4444_4444);
      drive(0, 1'b0, 32'h204, 32'h0, 4'hF);
      drive(1, 1'b0, 32'h304, 32'h0, 4'hF);
      wait_grants(2, 1'b1);

      // Core store: write command in one strobe, response data zero.
      @(posedge clk); #1;
      push_exp(0, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF, 32'h0);
      drive(0, 1'b1, 32'h20, 32'h1234_5678, 4'b0011);
      wait_grants(1, 1'b1);
      bus.core_we = 1'b0;

      // Reset during an aux read: no response, then the core wins the tie.
      @(posedge clk); #1;
      begin
         cmd_exp_t c;
         c.we = 1'b0; c.addr = 32'h400; c.wdata = 32'h0; c.be = 4'hF; c.ret = 32'hAAAA_AAAA;
         exp_cmd.push_back(c);
      end
      drive(1, 1'b0, 32'h400, 32'h0, 4'hF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.aux_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      busy = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.mem_en || bus.aux_valid || bus.core_valid) busy++;
      end
      check("D_reset_discards_access", 64'(busy), 64'(0));
      @(posedge clk); #1;
      push_exp(0, 1'b0, 32'h500, 32'h0, 4'hF, 32'h5555_5555, 32'h5555_5555);
      push_exp(1, 1'b0, 32'h504, 32'h0, 4'hF, 32'h6666_6666, 32'h6666_6666);
      drive(0, 1'b0, 32'h500, 32'h0, 4'hF);
      drive(1, 1'b0, 32'h504, 32'h0, 4'hF);
      wait_grants(2, 1'b1);

      // Aux request dropped after one cycle still completes, once, at T4.
      @(posedge clk); #1;
      t0 = cyc;
      push_exp(1, 1'b0, 32'h600, 32'h0, 4'hF, 32'h7777_7777, 32'h7777_7777);
      drive(1, 1'b0, 32'h600, 32'h0, 4'hF);
      @(posedge clk); #1;
      bus.aux_req = 1'b0;
      vcount = 0;
      vcyc = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.aux_valid) begin
            vcount++;
            vcyc = cyc - t0;
         end
      end
      check("E_aux_valid_count", 64'(vcount), 64'(1));
      check("E_aux_valid_cycle", 64'(vcyc), 64'(LAT + 2));

      repeat (3) @(posedge clk);
      check("left_cmd_expectations", 64'(exp_cmd.size()), 64'(0));
      check("left_rsp_expectations", 64'(exp_rsp.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
